// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter -- iterative AES SubBytes stage.
//
// Sits between the round-key add and ShiftRows. A whole block is loaded into
// a working register, then LANES bytes are substituted per clock through
// LANES forward and LANES inverse S-box instances until all G groups are
// done. The bytes are then presented downstream through a valid/ready
// handshake. An optional output holding register lets the next block load
// and substitute while the previous result still waits for the consumer.
//
// Ports
//   clk        in   1       clock, all state on rising edge
//   rst_n      in   1       synchronous reset, active low
//   in_valid   in   1       upstream block valid
//   in_ready   out  1       stage can accept a block (state is IDLE)
//   in_data    in   DATA_W  block, byte k = in_data[8k+8:8k+1]
//   in_first   in   1       1 = pass the block through unchanged
//   in_inv     in   1       1 = inverse S-box (decrypt), 0 = forward
//   out_valid  out  1       out_data holds a finished block
//   out_ready  in   1       downstream accepts
//   out_data   out  DATA_W  substituted block
//   busy       out  1       state is not IDLE
//
// The file also holds the two S-box leaf modules (sbox, inv_sbox). Both
// are computed algebraically: multiplicative inverse in GF(2^8) followed by
// (or preceded by) the AES affine transform.

// Forward AES S-box: y = affine(a^-1).
module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] xs;
      p  = 8'h00;
      xs = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ xs;
         xs = {xs[6:0], 1'b0} ^ (xs[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 == x^-1 for x != 0, and 0 maps to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] acc;
      logic [7:0] sq;
      acc = 8'h01;
      sq  = x;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   logic [7:0] b;

   assign b = gf_inv(a);
   assign y = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;

endmodule

// Inverse AES S-box: y = (inverse_affine(a))^-1.
module inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] xs;
      p  = 8'h00;
      xs = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ xs;
         xs = {xs[6:0], 1'b0} ^ (xs[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] acc;
      logic [7:0] sq;
      acc = 8'h01;
      sq  = x;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   logic [7:0] b;

   assign b = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
   assign y = gf_inv(b);

endmodule

module sub_bytes_iter #(
   parameter int DATA_W  = 128,
   parameter int LANES   = 4,
   parameter int OUT_REG = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DATA_W:1] in_data,
   input  logic            in_first,
   input  logic            in_inv,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DATA_W:1] out_data,
   output logic            busy
);

   localparam int G     = DATA_W / (8 * LANES);
   // A single group still gets a 1-bit counter so the declarations stay legal.
   localparam int CNT_W = (G > 1) ? $clog2(G) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(G - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W:1]   w_reg;
   logic [DATA_W:1]   o_reg;
   logic              ov;
   logic              inv_q;

   logic [7:0]        lane_in  [LANES];
   logic [7:0]        lane_fwd [LANES];
   logic [7:0]        lane_rev [LANES];
   logic [7:0]        lane_out [LANES];
   logic [DATA_W:1]   w_sub;

   // Pick the LANES bytes of the current group out of the working register.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_in[l] = 8'h00;
         for (int g = 0; g < G; g++) begin
            if (cnt == CNT_W'(g)) lane_in[l] = w_reg[8*(g*LANES+l)+1 +: 8];
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      sbox     u_fwd (.a(lane_in[l]), .y(lane_fwd[l]));
      inv_sbox u_inv (.a(lane_in[l]), .y(lane_rev[l]));
      assign lane_out[l] = inv_q ? lane_rev[l] : lane_fwd[l];
   end

   // Working register with the current group replaced by its substitutes.
   always_comb begin
      w_sub = w_reg;
      for (int g = 0; g < G; g++) begin
         for (int l = 0; l < LANES; l++) begin
            if (cnt == CNT_W'(g)) w_sub[8*(g*LANES+l)+1 +: 8] = lane_out[l];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         w_reg <= '0;
         o_reg <= '0;
         ov    <= 1'b0;
         inv_q <= 1'b0;
      end else begin
         // Consumer drains the holding register; a same-edge reload below wins.
         if ((OUT_REG != 0) && ov && out_ready) ov <= 1'b0;

         case (state)
            IDLE: begin
               if (in_valid) begin
                  w_reg <= in_data;
                  inv_q <= in_inv;
                  cnt   <= '0;
                  state <= in_first ? DONE : BUSY;
               end
            end
            BUSY: begin
               w_reg <= w_sub;
               if (cnt == LAST) begin
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (OUT_REG != 0) begin
                  if (!ov || out_ready) begin
                     o_reg <= w_reg;
                     ov    <= 1'b1;
                     state <= IDLE;
                  end
               end else if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (OUT_REG != 0) ? ov : (state == DONE);
   assign out_data  = (OUT_REG != 0) ? o_reg : w_reg;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter. Four instances share clock and reset:
//   0: LANES=4  OUT_REG=1     1: LANES=1  OUT_REG=0
//   2: LANES=4  OUT_REG=0     3: LANES=16 OUT_REG=0
// Expected blocks come from S-box tables built from log/antilog tables of
// GF(2^8) and the bitwise affine formula; the inverse table is obtained by
// inverting the forward table.
module tb_sub_bytes_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          in_valid  [4];
   logic          in_ready  [4];
   logic          in_first  [4];
   logic          in_inv    [4];
   logic          out_valid [4];
   logic          out_ready [4];
   logic          busy      [4];
   logic [128:1]  in_data   [4];
   logic [128:1]  out_data  [4];

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      sub_bytes_iter #(
         .DATA_W (128),
         .LANES  ((gi == 1) ? 1 : (gi == 3) ? 16 : 4),
         .OUT_REG((gi == 0) ? 1 : 0)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid[gi]),
         .in_ready (in_ready[gi]),
         .in_data  (in_data[gi]),
         .in_first (in_first[gi]),
         .in_inv   (in_inv[gi]),
         .out_valid(out_valid[gi]),
         .out_ready(out_ready[gi]),
         .out_data (out_data[gi]),
         .busy     (busy[gi])
      );
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic build_tables;
      logic [7:0] exp_t [256];
      int         log_t [256];
      logic [7:0] e;
      logic [7:0] b;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      e = 8'h01;
      for (int k = 0; k < 255; k++) begin
         exp_t[k] = e;
         log_t[e] = k;
         e = ({e[6:0], 1'b0} ^ (e[7] ? 8'h1b : 8'h00)) ^ e;   // multiply by 3
      end
      for (int x = 0; x < 256; x++) begin
         b = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
         for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
         sb[x] = s;
      end
      for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
   endtask

   function automatic logic [127:0] ref_sub(input logic [127:0] blk, input bit first, input bit inv);
      logic [127:0] r;
      r = blk;
      if (!first) begin
         for (int k = 0; k < 16; k++)
            r[8*k +: 8] = inv ? isb[blk[8*k +: 8]] : sb[blk[8*k +: 8]];
      end
      return r;
   endfunction

   // Edges from the accept edge until out_valid is seen.
   function automatic int lat(input int i, input bit first);
      int g;
      g = (i == 1) ? 16 : (i == 3) ? 1 : 4;
      return (first ? 0 : g) + ((i == 0) ? 1 : 0);
   endfunction

   task automatic run_one(input int i, input logic [127:0] d, input bit first, input bit inv,
                          input string tag, output logic [127:0] got);
      int edges;
      in_data[i]  = d;
      in_first[i] = first;
      in_inv[i]   = inv;
      in_valid[i] = 1'b1;
      edges = 0;
      while (!in_ready[i] && edges < 100) begin tick; edges++; end
      check({tag, "_rdy"}, 128'(in_ready[i]), 128'(1));
      tick;
      in_valid[i] = 1'b0;
      in_first[i] = ~first;   // must be ignored after acceptance
      in_inv[i]   = ~inv;
      edges = 0;
      while (!out_valid[i] && edges < 100) begin tick; edges++; end
      check({tag, "_lat"}, 128'(edges), 128'(lat(i, first)));
      got = out_data[i];
      check({tag, "_data"}, got, ref_sub(d, first, inv));
      out_ready[i] = 1'b1;
      tick;
      out_ready[i] = 1'b0;
      check({tag, "_drain"}, 128'(out_valid[i]), 128'(0));
   endtask

   initial begin
      logic [127:0] got, a_blk, b_blk, c_blk, pt, ct, ab, zero, all63;
      logic [127:0] q [$];
      bit           c_acc;
      int           n;

      build_tables();
      pt    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
      ct    = 128'hd42711aee0bf98f1b8b45de51e415230;
      ab    = 128'h00112233445566778899aabbccddeeff;
      zero  = '0;
      all63 = {16{8'h63}};

      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid[i] = 1'b0; in_first[i] = 1'b0; in_inv[i] = 1'b0;
         out_ready[i] = 1'b0; in_data[i] = '0;
      end
      tick; tick;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_ov%0d", i),  128'(out_valid[i]), 128'(0));
         check($sformatf("rst_ir%0d", i),  128'(in_ready[i]),  128'(1));
         check($sformatf("rst_bsy%0d", i), 128'(busy[i]),      128'(0));
         check($sformatf("rst_od%0d", i),  out_data[i],        zero);
      end
      rst_n = 1'b1;
      tick;

      // FIPS-197 round-1 SubBytes, forward and inverse
      run_one(0, pt, 1'b0, 1'b0, "fips_fwd0", got);  check("fips_fwd0_k", got, ct);
      run_one(2, pt, 1'b0, 1'b0, "fips_fwd2", got);  check("fips_fwd2_k", got, ct);
      run_one(0, ct, 1'b0, 1'b1, "fips_inv0", got);  check("fips_inv0_k", got, pt);
      run_one(3, ct, 1'b0, 1'b1, "fips_inv3", got);  check("fips_inv3_k", got, pt);

      // first-round bypass
      run_one(0, ab, 1'b1, 1'b0, "bypass0", got);    check("bypass0_k", got, ab);
      run_one(2, ab, 1'b1, 1'b1, "bypass2", got);    check("bypass2_k", got, ab);

      // all-zero block over 16 / 4 / 1 groups
      run_one(1, zero, 1'b0, 1'b0, "zero1", got);    check("zero1_k", got, all63);
      run_one(2, zero, 1'b0, 1'b0, "zero2", got);    check("zero2_k", got, all63);
      run_one(3, zero, 1'b0, 1'b0, "zero3", got);    check("zero3_k", got, all63);

      // random blocks, random direction
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 4; i++) begin
            run_one(i, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'($urandom_range(1)),
                    $sformatf("rnd%0d_%0d", r, i), got);
         end
      end

      // Back-pressure on the double-buffered instance: A in O, B in W, C stalled
      a_blk = {$urandom, $urandom, $urandom, $urandom};
      b_blk = {$urandom, $urandom, $urandom, $urandom};
      c_blk = {$urandom, $urandom, $urandom, $urandom};
      out_ready[0] = 1'b0;
      in_inv[0] = 1'b0; in_first[0] = 1'b0;
      in_data[0] = a_blk; in_valid[0] = 1'b1;
      tick;
      in_valid[0] = 1'b0;
      n = 0;
      while (!in_ready[0] && n < 50) begin tick; n++; end
      check("bp_a_idle", 128'(in_ready[0]), 128'(1));
      in_data[0] = b_blk; in_valid[0] = 1'b1;
      tick;
      in_valid[0] = 1'b0;
      for (int k = 0; k < 10; k++) tick;
      check("bp_a_hold_v", 128'(out_valid[0]), 128'(1));
      check("bp_a_hold_d", out_data[0], ref_sub(a_blk, 1'b0, 1'b0));
      in_data[0] = c_blk; in_valid[0] = 1'b1;
      for (int k = 0; k < 5; k++) tick;
      check("bp_c_stall", 128'(in_ready[0]), 128'(0));
      out_ready[0] = 1'b1;
      c_acc = 1'b0;
      n = 0;
      while (q.size() < 3 && n < 60) begin
         if (out_valid[0]) q.push_back(out_data[0]);
         if (in_valid[0] && in_ready[0]) c_acc = 1'b1;
         tick;
         if (c_acc) in_valid[0] = 1'b0;
         n++;
      end
      check("bp_count", 128'(q.size()), 128'(3));
      if (q.size() == 3) begin
         check("bp_out_a", q[0], ref_sub(a_blk, 1'b0, 1'b0));
         check("bp_out_b", q[1], ref_sub(b_blk, 1'b0, 1'b0));
         check("bp_out_c", q[2], ref_sub(c_blk, 1'b0, 1'b0));
      end
      tick; tick;
      check("bp_empty", 128'(out_valid[0]), 128'(0));
      out_ready[0] = 1'b0;

      // Reset with a held output (inst 0) and a block mid-substitution (inst 2)
      in_data[0] = ab; in_valid[0] = 1'b1;
      tick;
      in_valid[0] = 1'b0;
      n = 0;
      while (!out_valid[0] && n < 50) begin tick; n++; end
      check("rst_hold_v", 128'(out_valid[0]), 128'(1));
      in_data[2] = pt; in_inv[2] = 1'b0; in_first[2] = 1'b0; in_valid[2] = 1'b1;
      tick;
      in_valid[2] = 1'b0;
      tick; tick;
      check("rst_mid_busy", 128'(busy[2]), 128'(1));
      rst_n = 1'b0;
      tick;
      check("rst_mid_ov",  128'(out_valid[2]), 128'(0));
      check("rst_mid_ir",  128'(in_ready[2]),  128'(1));
      check("rst_mid_bsy", 128'(busy[2]),      128'(0));
      check("rst_mid_od",  out_data[2],        zero);
      check("rst_hold_ov", 128'(out_valid[0]), 128'(0));
      check("rst_hold_od", out_data[0],        zero);
      rst_n = 1'b1;
      tick;

      // Still functional after the reset
      run_one(2, pt, 1'b0, 1'b0, "post_rst", got);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
